// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational W-bit ALU between two requesters. Operations are
// accepted one at a time, round-robin between the requesters, and the chosen
// operation's opcode and operands are registered onto the ALU inputs. One
// cycle later the ALU result and N/Z status are captured and returned on the
// winning requester's response handshake.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reqN_valid / reqN_ready      operation request handshake (N = 0, 1)
//   reqN_op, reqN_a, reqN_b      opcode and operands of the request
//   rspN_valid / rspN_ready      response handshake
//   rspN_result, rspN_status     captured result and status
//                                (10 negative, 01 zero, 00 positive, 11 illegal)
//   alu_opcode, alu_in0, alu_in1 registered ALU inputs
//   alu_out, alu_status          ALU outputs
//   dbg_state_o                  current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. reqN_ready is a combinational function of the registered state
// and the valids; requesters hold valid/op/operands stable until ready.
// rspN_valid stays high with stable data until rspN_ready is seen.
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_result,
    output logic [1:0]   rsp0_status,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_result,
    output logic [1:0]   rsp1_status,
    output logic [2:0]   alu_opcode,
    output logic [W-1:0] alu_in0,
    output logic [W-1:0] alu_in1,
    input  logic [W-1:0] alu_out,
    input  logic [1:0]   alu_status,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t       state_q;
    logic         prio_q;     // requester favoured when both are valid
    logic         gnt_q;      // requester owning the in-flight operation
    logic [2:0]   op_q;
    logic [W-1:0] in0_q;
    logic [W-1:0] in1_q;
    logic [W-1:0] res_q;
    logic [1:0]   st_q;

    logic         gnt_d;      // requester that would be granted this cycle
    logic         accept;
    logic [2:0]   sel_op;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic         op_legal;
    logic         rsp_done;

    always_comb begin
        gnt_d = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_d = prio_q;
        end else begin
            // Only one (or no) requester valid: it wins regardless of prio.
            gnt_d = req1_valid;
        end
    end

    // Grants only in IDLE and never while reset is asserted.
    assign accept     = (state_q == S_IDLE) && !rst && (req0_valid || req1_valid);
    assign req0_ready = accept && !gnt_d;
    assign req1_ready = accept && gnt_d;

    assign sel_op = gnt_d ? req1_op : req0_op;
    assign sel_a  = gnt_d ? req1_a  : req0_a;
    assign sel_b  = gnt_d ? req1_b  : req0_b;

    assign op_legal = (op_q <= 3'd4);
    assign rsp_done = (state_q == S_RESP) && (gnt_q ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            gnt_q   <= 1'b0;
            op_q    <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
            res_q   <= '0;
            st_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= sel_op;
                        in0_q   <= sel_a;
                        in1_q   <= sel_b;
                        gnt_q   <= gnt_d;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Opcodes 101-111 are not ALU operations; the ALU output
                    // is whatever it happens to produce, so it is discarded.
                    if (op_legal) begin
                        res_q <= alu_out;
                        st_q  <= alu_status;
                    end else begin
                        res_q <= '0;
                        st_q  <= 2'b11;
                    end
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_done) begin
                        // Favour the requester that was not just served.
                        prio_q  <= ~gnt_q;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp0_valid  = (state_q == S_RESP) && !gnt_q;
    assign rsp1_valid  = (state_q == S_RESP) && gnt_q;
    assign rsp0_result = res_q;
    assign rsp1_result = res_q;
    assign rsp0_status = st_q;
    assign rsp1_status = st_q;

    assign alu_opcode  = op_q;
    assign alu_in0     = in0_q;
    assign alu_in1     = in1_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Bench for alu_arbiter: a stand-in ALU, a transaction-level reference model
// of the arbiter, a per-cycle compare process, directed scenarios with
// literal expectations, and a randomized phase.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [2:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [W-1:0] rsp0_result, rsp1_result;
    logic [1:0]   rsp0_status, rsp1_status;
    logic [2:0]   alu_opcode;
    logic [W-1:0] alu_in0, alu_in1;
    logic [W-1:0] alu_out;
    logic [1:0]   alu_status;
    logic [1:0]   dbg_state;

    alu_arbiter #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_status(rsp0_status),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_status(rsp1_status),
        .alu_opcode(alu_opcode), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_out(alu_out), .alu_status(alu_status),
        .dbg_state_o(dbg_state)
    );

    // ---------------- arithmetic reference ----------------
    // Returns {status, result}.
    function automatic logic [W+1:0] ref_alu(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [1:0]   s;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = a + b;
            3'd4: r = a - b;
            default: return {2'b11, {W{1'b0}}};
        endcase
        if (r[W-1]) s = 2'b10;
        else if (r == '0) s = 2'b01;
        else s = 2'b00;
        return {s, r};
    endfunction

    // Stand-in ALU; illegal opcodes produce junk that must be ignored.
    always_comb begin
        alu_out    = 16'hDEAD;
        alu_status = 2'b01;
        if (alu_opcode <= 3'd4) {alu_status, alu_out} = ref_alu(alu_opcode, alu_in0, alu_in1);
    end

    // ---------------- reference model ----------------
    // Transaction view: at most one operation in flight; it becomes visible
    // as a response two cycles after the accept cycle and stays until taken.
    logic         m_busy = 1'b0;
    logic [1:0]   m_age = '0;      // cycles since acceptance, saturating at 2
    logic         m_id = 1'b0;
    logic         m_prio = 1'b0;
    logic [W-1:0] m_res = '0;
    logic [1:0]   m_st = '0;
    logic [2:0]   m_op = '0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [1:0]   m_acc = '0;      // one-hot: which requester was accepted at the last edge
    logic [1:0]   m_grant;
    logic [2:0]   w_op;
    logic [W-1:0] w_a, w_b;

    function automatic logic [1:0] pick(input logic v0, input logic v1,
                                        input logic prio, input logic busy,
                                        input logic r);
        if (r || busy) return 2'b00;
        if (v0 && v1) return prio ? 2'b10 : 2'b01;
        return {v1, v0};
    endfunction

    assign m_grant = pick(req0_valid, req1_valid, m_prio, m_busy, rst);
    assign w_op = m_grant[1] ? req1_op : req0_op;
    assign w_a  = m_grant[1] ? req1_a  : req0_a;
    assign w_b  = m_grant[1] ? req1_b  : req0_b;

    always @(posedge clk) begin
        m_acc <= 2'b00;
        if (rst) begin
            m_busy <= 1'b0;
            m_age  <= '0;
            m_id   <= 1'b0;
            m_prio <= 1'b0;
            m_op   <= '0;
            m_a    <= '0;
            m_b    <= '0;
        end else if (m_grant != 2'b00) begin
            m_acc  <= m_grant;
            m_busy <= 1'b1;
            m_age  <= 2'd1;
            m_id   <= m_grant[1];
            {m_st, m_res} <= ref_alu(w_op, w_a, w_b);
            m_op   <= w_op;
            m_a    <= w_a;
            m_b    <= w_b;
        end else if (m_busy) begin
            if (m_age < 2'd2) m_age <= m_age + 2'd1;
            else if (m_id ? rsp1_ready : rsp0_ready) begin
                m_busy <= 1'b0;
                m_prio <= ~m_id;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic ev0, ev1;
            ev0 = m_busy && (m_age == 2'd2) && !m_id;
            ev1 = m_busy && (m_age == 2'd2) && m_id;
            chk("m_req0_ready", {31'd0, req0_ready}, {31'd0, m_grant[0]});
            chk("m_req1_ready", {31'd0, req1_ready}, {31'd0, m_grant[1]});
            chk("m_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, ev0});
            chk("m_rsp1_valid", {31'd0, rsp1_valid}, {31'd0, ev1});
            if (ev0) chk("m_rsp0_data", {14'd0, rsp0_status, rsp0_result}, {14'd0, m_st, m_res});
            if (ev1) chk("m_rsp1_data", {14'd0, rsp1_status, rsp1_result}, {14'd0, m_st, m_res});
            chk("m_alu_inputs", {13'd0, alu_opcode, alu_in0}, {13'd0, m_op, m_a});
            chk("m_alu_in1", {16'd0, alu_in1}, {16'd0, m_b});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int n);
        return (n != 0) ? req1_ready : req0_ready;
    endfunction

    task automatic drive(input int n, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        if (n == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic drop(input int n);
        if (n == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic wait_ready(input int n);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            got = rdy(n);
            cyc();
            if (got) break;
        end
        chk("ready_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_rsp(input int n, output logic [W-1:0] res, output logic [1:0] st);
        logic got;
        got = 1'b0;
        res = '0;
        st  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((n != 0) ? rsp1_valid : rsp0_valid) begin
                got = 1'b1;
                res = (n != 0) ? rsp1_result : rsp0_result;
                st  = (n != 0) ? rsp1_status : rsp0_status;
            end
            cyc();
            if (got) break;
        end
        chk("rsp_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic run_op(input int n, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output logic [W-1:0] res,
                          output logic [1:0] st);
        if (n == 0) rsp0_ready = 1'b1;
        else rsp1_ready = 1'b1;
        drive(n, op, a, b);
        wait_ready(n);
        drop(n);
        wait_rsp(n, res, st);
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    logic [18:0]  exp_q[$];   // {id, status, result}
    logic [W-1:0] res;
    logic [1:0]   st;

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_alu_opcode", {29'd0, alu_opcode}, 32'd0);
        chk("rst_alu_in0", {16'd0, alu_in0}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        cyc();

        // Single op, requester 0: ADD 0x7FFF + 0x0001.
        rsp0_ready = 1'b1;
        drive(0, 3'd3, 16'h7FFF, 16'h0001);
        @(negedge clk);
        chk("single_ready", {31'd0, req0_ready}, 32'd1);
        cyc();
        drop(0);
        @(negedge clk);
        chk("single_ready_once", {31'd0, req0_ready}, 32'd0);
        chk("single_no_rsp_yet", {31'd0, rsp0_valid}, 32'd0);
        cyc();
        @(negedge clk);
        chk("single_rsp_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("single_result", {16'd0, rsp0_result}, 32'h8000);
        chk("single_status", {30'd0, rsp0_status}, 32'd2);
        cyc();
        @(negedge clk);
        chk("single_rsp_one_cycle", {31'd0, rsp0_valid}, 32'd0);
        cyc();

        // Contention from reset: both requesters valid continuously.
        rst = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive(0, 3'd4, 16'd5, 16'd5);
        drive(1, 3'd1, 16'h00F0, 16'h000F);
        @(negedge clk);
        chk("rst_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b0, 2'b01, 16'h0000});
            exp_q.push_back({1'b1, 2'b00, 16'h00FF});
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) begin
                if (exp_q.size() == 0) chk("contention_extra", 32'd1, 32'd0);
                else chk("contention_rsp",
                         {13'd0, rsp1_valid, (rsp1_valid ? rsp1_status : rsp0_status),
                          (rsp1_valid ? rsp1_result : rsp0_result)},
                         {13'd0, exp_q.pop_front()});
            end
            cyc();
        end
        chk("contention_left", exp_q.size(), 32'd0);
        drop(0);
        drop(1);

        // Backpressure: serve req0 once so req1 is favoured, then stall rsp1.
        run_op(0, 3'd0, 16'h00FF, 16'h0F00, res, st);
        chk("bp_pre_result", {14'd0, st, res}, {14'd0, 2'b01, 16'h0000});
        rsp1_ready = 1'b0;
        rsp0_ready = 1'b1;
        drive(0, 3'd0, 16'h1234, 16'hFF00);
        drive(1, 3'd2, 16'hAAAA, 16'h5555);
        @(negedge clk);
        chk("bp_grant1", {30'd0, req1_ready, req0_ready}, 32'b10);
        cyc();
        drop(1);
        @(negedge clk);
        chk("bp_exec_no_ready", {31'd0, req0_ready}, 32'd0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
            chk("bp_rsp1_data", {14'd0, rsp1_status, rsp1_result}, {14'd0, 2'b10, 16'hFFFF});
            chk("bp_req0_blocked", {31'd0, req0_ready}, 32'd0);
            cyc();
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("bp_rsp1_still", {31'd0, rsp1_valid}, 32'd1);
        cyc();
        @(negedge clk);
        chk("bp_rsp1_gone", {31'd0, rsp1_valid}, 32'd0);
        chk("bp_req0_now", {31'd0, req0_ready}, 32'd1);
        cyc();
        drop(0);
        wait_rsp(0, res, st);
        chk("bp_req0_result", {14'd0, st, res}, {14'd0, 2'b00, 16'h1200});

        // Illegal opcode, then a legal op.
        run_op(0, 3'b110, 16'h1234, 16'h5678, res, st);
        chk("illegal_result", {14'd0, st, res}, {14'd0, 2'b11, 16'h0000});
        run_op(0, 3'd3, 16'd1, 16'd2, res, st);
        chk("after_illegal", {14'd0, st, res}, {14'd0, 2'b00, 16'h0003});

        // Reset mid-operation (priority currently favours requester 1).
        rsp1_ready = 1'b1;
        drive(1, 3'd3, 16'h0001, 16'h0001);
        @(negedge clk);
        chk("rmid_accept", {31'd0, req1_ready}, 32'd1);
        cyc();
        drop(1);
        rst = 1'b1;
        @(negedge clk);
        chk("rmid_in_exec", {30'd0, dbg_state}, 32'd1);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rmid_zero_ctl", {28'd0, req1_ready, req0_ready, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rmid_zero_alu", {13'd0, alu_opcode, alu_in0}, 32'd0);
        chk("rmid_zero_in1", {16'd0, alu_in1}, 32'd0);
        chk("rmid_zero_res", {14'd0, rsp1_status, rsp1_result}, 32'd0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rmid_no_rsp", {31'd0, rsp1_valid}, 32'd0);
            cyc();
        end
        rsp0_ready = 1'b1;
        drive(0, 3'd1, 16'h0100, 16'h0001);
        drive(1, 3'd4, 16'h0000, 16'h0001);
        @(negedge clk);
        chk("rmid_prio0", {30'd0, req1_ready, req0_ready}, 32'b01);
        cyc();
        drop(0);
        wait_rsp(0, res, st);
        chk("rmid_r0", {14'd0, st, res}, {14'd0, 2'b00, 16'h0101});
        wait_ready(1);
        drop(1);
        wait_rsp(1, res, st);
        chk("rmid_r1", {14'd0, st, res}, {14'd0, 2'b10, 16'hFFFF});

        // Idle/hold after AND 0x0F0F & 0x00FF.
        run_op(0, 3'd0, 16'h0F0F, 16'h00FF, res, st);
        chk("hold_result", {14'd0, st, res}, {14'd0, 2'b00, 16'h000F});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_quiet", {28'd0, req1_ready, req0_ready, rsp1_valid, rsp0_valid}, 32'd0);
            chk("hold_alu", {13'd0, alu_opcode, alu_in0}, {13'd0, 3'd0, 16'h0F0F});
            chk("hold_in1", {16'd0, alu_in1}, 32'h00FF);
            cyc();
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!req0_valid || m_acc[0]) begin
                if ($urandom_range(0, 3) != 0) begin
                    drive(0, ($urandom_range(0, 9) > 7) ? 3'd3 : 3'($urandom_range(0, 7)),
                          rand_val(), rand_val());
                end else drop(0);
            end
            if (!req1_valid || m_acc[1]) begin
                if ($urandom_range(0, 3) != 0) begin
                    drive(1, ($urandom_range(0, 9) > 7) ? 3'd4 : 3'($urandom_range(0, 7)),
                          rand_val(), rand_val());
                end else drop(1);
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0;
        drop(0);
        drop(1);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (6) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
